// File: rtl/tube_pkg.sv
// Shared constants for the seven-segment tube display controller:
// active-low segment codes, register offsets and the blank pattern.
package tube_pkg;

    // Active-low segment patterns, bit0 = a ... bit6 = g, bit7 = dp (off)
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    // All segments dark
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Bus word offsets
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_AUX  = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;

    // CTRL after reset: display enabled, group 2 dp off
    localparam logic [1:0] CTRL_RESET = 2'b01;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
// The decimal point (bit7) is always returned dark.
module seg7_decode
    import tube_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] seg_o
);

    // Look up the segment pattern for the nibble
    always_comb begin
        seg_o = SEG_BLANK;
        case (nib_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            4'hF:    seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/tube_display_ctrl.sv
// Bus-slave seven-segment tube controller. Holds a 32-bit display word,
// a 4-bit auxiliary digit and a control register, and time-multiplexes
// the word onto two 4-digit groups while group 2 shows the aux digit.
// Select and segment outputs are registered together so they never skew.
module tube_display_ctrl
    import tube_pkg::*;
#(
    parameter int SCAN_DIV = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  digital_tube_sel0,
    output logic [3:0]  digital_tube_sel1,
    output logic        digital_tube_sel2,
    output logic [7:0]  digital_tube0,
    output logic [7:0]  digital_tube1,
    output logic [7:0]  digital_tube2
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      data_q, data_d;
    logic [3:0]       aux_q, aux_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;

    logic [3:0]       sel0_q, sel0_d;
    logic [3:0]       sel1_q, sel1_d;
    logic             sel2_q, sel2_d;
    logic [7:0]       tube0_q, tube0_d;
    logic [7:0]       tube1_q, tube1_d;
    logic [7:0]       tube2_q, tube2_d;

    logic [3:0]       nib0_s, nib1_s;
    logic [7:0]       seg0_s, seg1_s, seg2_s;

    seg7_decode u_dec0 (.nib_i(nib0_s), .seg_o(seg0_s));
    seg7_decode u_dec1 (.nib_i(nib1_s), .seg_o(seg1_s));
    seg7_decode u_dec2 (.nib_i(aux_q),  .seg_o(seg2_s));

    // Register file update from bus writes; offset 3 is ignored
    always_comb begin
        data_d = data_q;
        aux_d  = aux_q;
        ctrl_d = ctrl_q;
        if (we) begin
            case (addr)
                ADDR_DATA: data_d = wdata;
                ADDR_AUX:  aux_d  = wdata[3:0];
                ADDR_CTRL: ctrl_d = wdata[1:0];
                default:   data_d = data_q;
            endcase
        end else begin
            data_d = data_q;
        end
    end

    // Scan timer: hold each digit SCAN_DIV cycles, then step the position
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    // Pick the nibble for the current digit position of each group
    always_comb begin
        nib0_s = 4'h0;
        nib1_s = 4'h0;
        case (idx_q)
            2'd0: begin nib0_s = data_q[3:0];   nib1_s = data_q[19:16]; end
            2'd1: begin nib0_s = data_q[7:4];   nib1_s = data_q[23:20]; end
            2'd2: begin nib0_s = data_q[11:8];  nib1_s = data_q[27:24]; end
            2'd3: begin nib0_s = data_q[15:12]; nib1_s = data_q[31:28]; end
            default: begin nib0_s = 4'h0; nib1_s = 4'h0; end
        endcase
    end

    // Next display outputs; EN low blanks everything but the scan keeps going
    always_comb begin
        sel0_d  = 4'b0000;
        sel1_d  = 4'b0000;
        sel2_d  = 1'b0;
        tube0_d = SEG_BLANK;
        tube1_d = SEG_BLANK;
        tube2_d = SEG_BLANK;
        if (ctrl_q[0]) begin
            sel0_d  = 4'b0001 << idx_q;
            sel1_d  = 4'b0001 << idx_q;
            sel2_d  = 1'b1;
            tube0_d = seg0_s;
            tube1_d = seg1_s;
            // decoder leaves dp dark; DP2 pulls it low
            tube2_d = {seg2_s[7] & ~ctrl_q[1], seg2_s[6:0]};
        end else begin
            sel2_d  = 1'b0;
        end
    end

    // Read-back mux; unused bits and the reserved offset read as zero
    always_comb begin
        rdata = 32'h0000_0000;
        case (addr)
            ADDR_DATA: rdata = data_q;
            ADDR_AUX:  rdata = {28'h000_0000, aux_q};
            ADDR_CTRL: rdata = {30'h0000_0000, ctrl_q};
            default:   rdata = 32'h0000_0000;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= 32'h0000_0000;
            aux_q   <= 4'h0;
            ctrl_q  <= CTRL_RESET;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            sel0_q  <= 4'b0001;
            sel1_q  <= 4'b0001;
            sel2_q  <= 1'b1;
            tube0_q <= SEG_0;
            tube1_q <= SEG_0;
            tube2_q <= SEG_0;
        end else begin
            data_q  <= data_d;
            aux_q   <= aux_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sel0_q  <= sel0_d;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
            tube0_q <= tube0_d;
            tube1_q <= tube1_d;
            tube2_q <= tube2_d;
        end
    end

    assign digital_tube_sel0 = sel0_q;
    assign digital_tube_sel1 = sel1_q;
    assign digital_tube_sel2 = sel2_q;
    assign digital_tube0     = tube0_q;
    assign digital_tube1     = tube1_q;
    assign digital_tube2     = tube2_q;

endmodule

// File: tb/tb_tube_display_ctrl.sv
// Directed bench for tube_display_ctrl with SCAN_DIV = 4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge;
// k counts rising edges since the last reset edge.
module tb_tube_display_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [3:0]  sel0, sel1;
    logic        sel2;
    logic [7:0]  tube0, tube1, tube2;

    int vec_cnt = 0;
    int err_cnt = 0;
    int k = 0;

    tube_display_ctrl #(.SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata),
        .digital_tube_sel0(sel0), .digital_tube_sel1(sel1),
        .digital_tube_sel2(sel2),
        .digital_tube0(tube0), .digital_tube1(tube1), .digital_tube2(tube2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        we = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        k = 0;
    endtask

    task automatic test_reset();
        we = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        k = 0;
        addr = 2'd2;
        #1;
        vec_cnt++;
        if ({sel0, sel1, sel2} !== {4'b0001, 4'b0001, 1'b1}) begin
            err_cnt++;
            $display("FAIL reset_sel got %b %b %b exp 0001 0001 1", sel0, sel1, sel2);
        end
        vec_cnt++;
        if ({tube0, tube1, tube2} !== {8'hC0, 8'hC0, 8'hC0}) begin
            err_cnt++;
            $display("FAIL reset_tubes got %h %h %h exp c0 c0 c0", tube0, tube1, tube2);
        end
        vec_cnt++;
        if (rdata !== 32'h0000_0001) begin
            err_cnt++;
            $display("FAIL reset_rdata_ctrl got %h exp 00000001", rdata);
        end
    endtask

    task automatic test_full_scan();
        logic [7:0] t0_tab [4] = '{8'hF8, 8'hC0, 8'hC0, 8'hC0};
        logic [7:0] t1_tab [4] = '{8'h83, 8'h88, 8'h90, 8'h80};
        logic [3:0] s_tab  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        int e;
        do_reset();
        we = 1'b1; addr = 2'd0; wdata = 32'h89AB_0007;
        tick();
        we = 1'b0;
        vec_cnt++;
        if (rdata !== 32'h89AB_0007) begin
            err_cnt++;
            $display("FAIL scan_rdata got %h exp 89ab0007", rdata);
        end
        // data visible from edge 2; idx shown after edge k is ((k-1)/4)%4
        for (int j = 2; j <= 20; j++) begin
            tick();
            e = ((k - 1) / 4) % 4;
            vec_cnt++;
            if (sel0 !== s_tab[e] || sel1 !== s_tab[e] || sel2 !== 1'b1) begin
                err_cnt++;
                $display("FAIL scan_sel k=%0d got %b %b %b exp %b %b 1",
                         k, sel0, sel1, sel2, s_tab[e], s_tab[e]);
            end
            vec_cnt++;
            if (tube0 !== t0_tab[e] || tube1 !== t1_tab[e] || tube2 !== 8'hC0) begin
                err_cnt++;
                $display("FAIL scan_tubes k=%0d got %h %h %h exp %h %h c0",
                         k, tube0, tube1, tube2, t0_tab[e], t1_tab[e]);
            end
        end
    endtask

    task automatic test_aux_dp();
        do_reset();
        we = 1'b1; addr = 2'd1; wdata = 32'hFFFF_FFFE;
        tick();
        vec_cnt++;
        if (rdata !== 32'h0000_000E) begin
            err_cnt++;
            $display("FAIL aux_rdata got %h exp 0000000e", rdata);
        end
        addr = 2'd2; wdata = 32'h0000_0003;
        tick();
        we = 1'b0;
        vec_cnt++;
        if (tube2 !== 8'h86) begin
            err_cnt++;
            $display("FAIL aux_tube2_nodp got %h exp 86", tube2);
        end
        tick();
        vec_cnt++;
        if (tube2 !== 8'h06) begin
            err_cnt++;
            $display("FAIL aux_tube2_dp got %h exp 06", tube2);
        end
        we = 1'b1; addr = 2'd2; wdata = 32'h0000_0001;
        tick();
        we = 1'b0;
        vec_cnt++;
        if (tube2 !== 8'h06) begin
            err_cnt++;
            $display("FAIL aux_tube2_hold got %h exp 06", tube2);
        end
        tick();
        vec_cnt++;
        if (tube2 !== 8'h86) begin
            err_cnt++;
            $display("FAIL aux_tube2_dpoff got %h exp 86", tube2);
        end
    endtask

    task automatic test_blanking();
        do_reset();
        we = 1'b1; addr = 2'd0; wdata = 32'h89AB_0007;
        tick();
        addr = 2'd2; wdata = 32'h0000_0000;
        tick();
        we = 1'b0;
        tick();
        vec_cnt++;
        if ({sel0, sel1, sel2} !== 9'b0 || {tube0, tube1, tube2} !== 24'hFFFFFF) begin
            err_cnt++;
            $display("FAIL blank_on got %b %b %b %h %h %h exp all off",
                     sel0, sel1, sel2, tube0, tube1, tube2);
        end
        while (k < 9) tick();
        vec_cnt++;
        if (sel0 !== 4'b0000 || tube0 !== 8'hFF) begin
            err_cnt++;
            $display("FAIL blank_hold got %b %h exp 0000 ff", sel0, tube0);
        end
        // re-enable at edge 10 (idx 2 after that edge)
        we = 1'b1; addr = 2'd2; wdata = 32'h0000_0001;
        tick();
        we = 1'b0;
        tick();
        vec_cnt++;
        if (sel0 !== 4'b0100 || sel1 !== 4'b0100 || sel2 !== 1'b1) begin
            err_cnt++;
            $display("FAIL blank_resume_sel got %b %b %b exp 0100 0100 1", sel0, sel1, sel2);
        end
        vec_cnt++;
        if (tube0 !== 8'hC0 || tube1 !== 8'h90 || tube2 !== 8'hC0) begin
            err_cnt++;
            $display("FAIL blank_resume_tubes got %h %h %h exp c0 90 c0", tube0, tube1, tube2);
        end
    endtask

    task automatic test_wrap_write();
        do_reset();
        while (k < 15) tick();
        // after edge 15: cnt = 3, idx = 3
        we = 1'b1; addr = 2'd0; wdata = 32'h0000_0005;
        tick();
        we = 1'b0;
        vec_cnt++;
        if (sel0 !== 4'b1000 || tube0 !== 8'hC0) begin
            err_cnt++;
            $display("FAIL wrap_before got %b %h exp 1000 c0", sel0, tube0);
        end
        tick();
        vec_cnt++;
        if (sel0 !== 4'b0001 || tube0 !== 8'h92 || tube1 !== 8'hC0) begin
            err_cnt++;
            $display("FAIL wrap_after got %b %h %h exp 0001 92 c0", sel0, tube0, tube1);
        end
        we = 1'b1; addr = 2'd3; wdata = 32'hFFFF_FFFF;
        tick();
        we = 1'b0;
        vec_cnt++;
        if (rdata !== 32'h0) begin
            err_cnt++;
            $display("FAIL resv_rdata got %h exp 00000000", rdata);
        end
        addr = 2'd0; #1;
        vec_cnt++;
        if (rdata !== 32'h0000_0005) begin
            err_cnt++;
            $display("FAIL resv_data got %h exp 00000005", rdata);
        end
        addr = 2'd1; #1;
        vec_cnt++;
        if (rdata !== 32'h0) begin
            err_cnt++;
            $display("FAIL resv_aux got %h exp 00000000", rdata);
        end
        addr = 2'd2; #1;
        vec_cnt++;
        if (rdata !== 32'h0000_0001) begin
            err_cnt++;
            $display("FAIL resv_ctrl got %h exp 00000001", rdata);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        we = 1'b1; addr = 2'd0; wdata = 32'hFFFF_FFFF;
        tick();
        we = 1'b0;
        while (k < 8) tick();
        vec_cnt++;
        if (sel0 !== 4'b0010 || tube0 !== 8'h8E || tube1 !== 8'h8E) begin
            err_cnt++;
            $display("FAIL mid_before got %b %h %h exp 0010 8e 8e", sel0, tube0, tube1);
        end
        // after edge 8 idx = 2; reset with a concurrent write
        reset = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'h1234_5678;
        tick();
        reset = 1'b0; we = 1'b0;
        #1;
        vec_cnt++;
        if ({sel0, sel1, sel2} !== {4'b0001, 4'b0001, 1'b1} ||
            {tube0, tube1, tube2} !== {8'hC0, 8'hC0, 8'hC0}) begin
            err_cnt++;
            $display("FAIL mid_reset_out got %b %b %b %h %h %h exp 0001 0001 1 c0 c0 c0",
                     sel0, sel1, sel2, tube0, tube1, tube2);
        end
        vec_cnt++;
        if (rdata !== 32'h0) begin
            err_cnt++;
            $display("FAIL mid_reset_data got %h exp 00000000", rdata);
        end
        k = 0;
        tick();
        tick();
        vec_cnt++;
        if (sel0 !== 4'b0001 || tube0 !== 8'hC0) begin
            err_cnt++;
            $display("FAIL mid_restart got %b %h exp 0001 c0", sel0, tube0);
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_aux_dp();
        test_blanking();
        test_wrap_write();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
